// File: rtl/mmio_uart_fifo_if.sv
// rtl/mmio_uart_fifo_if.sv - data-memory bus port bundle for the MMIO UART
interface mmio_uart_fifo_if;
  logic        mem_we;
  logic        mem_re;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (output mem_we, mem_re, mem_addr, mem_wdata, input mem_rdata);
  modport slave  (input mem_we, mem_re, mem_addr, mem_wdata, output mem_rdata);
endinterface

// File: rtl/mmio_uart_fifo.sv
// rtl/mmio_uart_fifo.sv - MMIO UART with TX/RX FIFOs, optional parity, loopback and sticky errors
module mmio_uart_fifo #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 200000,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  mmio_uart_fifo_if.slave  bus,
  output logic             uart_tx,
  input  logic             uart_rx,
  output logic             irq
);
  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int HALF = CPB / 2;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CPB);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [7:0] ctrl;
  logic ovr, ferr, perr, tx_drop;

  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [AW:0] tx_cnt, rx_cnt;

  state_t tx_state, rx_state;
  logic [CW-1:0] tx_clk, rx_clk;
  logic [3:0] tx_bit, rx_bit;
  logic [DATA_BITS-1:0] tx_sh, rx_sh;
  logic tx_par;
  logic rx_s1, rx_s2, rx_s3;

  logic wr_data, wr_stat, wr_ctrl, rd_data;
  logic tx_empty, tx_full, rx_empty, rx_full;
  logic tx_end, tx_pop, tx_push, drop_set;
  logic rx_sample, rx_stop_ok, rx_push, rx_pop, ovr_set, ferr_set, perr_set;
  logic [DATA_BITS-1:0] tx_head;
  logic unused_bits;

  assign unused_bits = ^bus.mem_wdata;

  assign wr_data = bus.mem_we && bus.mem_addr == 4'h0;
  assign wr_stat = bus.mem_we && bus.mem_addr == 4'h4;
  assign wr_ctrl = bus.mem_we && bus.mem_addr == 4'h8;
  assign rd_data = bus.mem_re && bus.mem_addr == 4'h0;

  assign tx_empty = tx_cnt == '0;
  assign tx_full  = tx_cnt == FULL_CNT;
  assign rx_empty = rx_cnt == '0;
  assign rx_full  = rx_cnt == FULL_CNT;
  assign tx_head  = tx_mem[tx_rp];

  // A frame starts either from IDLE or straight out of the final STOP cycle, so back-to-back frames have no gap.
  assign tx_end   = tx_clk == CW'(CPB - 1);
  assign tx_pop   = ctrl[0] && !tx_empty && (tx_state == S_IDLE || (tx_state == S_STOP && tx_end));
  assign tx_push  = wr_data && (!tx_full || tx_pop);
  assign drop_set = wr_data && tx_full && !tx_pop;

  assign rx_sample  = (rx_state == S_START) ? (rx_clk == CW'(HALF - 1)) : (rx_clk == CW'(CPB - 1));
  assign rx_stop_ok = rx_state == S_STOP && rx_sample && rx_s2;
  assign rx_pop     = rd_data && !rx_empty;
  assign rx_push    = rx_stop_ok && (!rx_full || rx_pop);
  assign ovr_set    = rx_stop_ok && rx_full && !rx_pop;
  assign ferr_set   = rx_state == S_STOP && rx_sample && !rx_s2;
  assign perr_set   = rx_state == S_PARITY && rx_sample && (rx_s2 != (^rx_sh ^ ctrl[3]));

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl <= '0;
      ovr <= 1'b0;
      ferr <= 1'b0;
      perr <= 1'b0;
      tx_drop <= 1'b0;
      bus.mem_rdata <= '0;
      irq <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl <= bus.mem_wdata[7:0];
      // Hardware set takes priority over a same-cycle write-1-to-clear.
      ovr     <= ovr_set  | (ovr     & ~(wr_stat & bus.mem_wdata[5]));
      ferr    <= ferr_set | (ferr    & ~(wr_stat & bus.mem_wdata[6]));
      perr    <= perr_set | (perr    & ~(wr_stat & bus.mem_wdata[7]));
      tx_drop <= drop_set | (tx_drop & ~(wr_stat & bus.mem_wdata[8]));
      if (bus.mem_re) begin
        case (bus.mem_addr)
          4'h0: bus.mem_rdata <= rx_empty ? 32'h0 : {{(32-DATA_BITS){1'b0}}, rx_mem[rx_rp]};
          4'h4: bus.mem_rdata <= {23'h0, tx_drop, perr, ferr, ovr, tx_state != S_IDLE,
                                  rx_empty, rx_full, tx_empty, tx_full};
          4'h8: bus.mem_rdata <= {24'h0, ctrl};
          default: bus.mem_rdata <= 32'h0;
        endcase
      end
      irq <= (ctrl[5] & ~rx_empty) | (ctrl[6] & tx_empty & (tx_state == S_IDLE))
           | (ctrl[7] & (ovr | ferr | perr | tx_drop));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0;
      rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0;
    end else begin
      if (tx_push) begin
        tx_mem[tx_wp] <= bus.mem_wdata[DATA_BITS-1:0];
        tx_wp <= tx_wp + AW'(1);
      end
      if (tx_pop) tx_rp <= tx_rp + AW'(1);
      case ({tx_push, tx_pop})
        2'b10: tx_cnt <= tx_cnt + (AW+1)'(1);
        2'b01: tx_cnt <= tx_cnt - (AW+1)'(1);
        default: ;
      endcase
      if (rx_push) begin
        rx_mem[rx_wp] <= rx_sh;
        rx_wp <= rx_wp + AW'(1);
      end
      if (rx_pop) rx_rp <= rx_rp + AW'(1);
      case ({rx_push, rx_pop})
        2'b10: rx_cnt <= rx_cnt + (AW+1)'(1);
        2'b01: rx_cnt <= rx_cnt - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= S_IDLE; tx_clk <= '0; tx_bit <= '0;
      tx_sh <= '0; tx_par <= 1'b0; uart_tx <= 1'b1;
    end else if (tx_pop) begin
      tx_state <= S_START; tx_clk <= '0;
      tx_sh <= tx_head; tx_par <= ^tx_head ^ ctrl[3]; uart_tx <= 1'b0;
    end else begin
      tx_clk <= (tx_end || tx_state == S_IDLE) ? '0 : tx_clk + CW'(1);
      case (tx_state)
        S_START: if (tx_end) begin
          tx_state <= S_DATA; tx_bit <= '0; uart_tx <= tx_sh[0];
        end
        S_DATA: if (tx_end) begin
          if (tx_bit == LAST_BIT) begin
            tx_state <= ctrl[2] ? S_PARITY : S_STOP;
            uart_tx  <= ctrl[2] ? tx_par : 1'b1;
          end else begin
            tx_bit <= tx_bit + 4'd1; tx_sh <= tx_sh >> 1; uart_tx <= tx_sh[1];
          end
        end
        S_PARITY: if (tx_end) begin tx_state <= S_STOP; uart_tx <= 1'b1; end
        S_STOP:   if (tx_end) tx_state <= S_IDLE;
        default:  uart_tx <= 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1; rx_s2 <= 1'b1; rx_s3 <= 1'b1;
      rx_state <= S_IDLE; rx_clk <= '0; rx_bit <= '0; rx_sh <= '0;
    end else begin
      rx_s1 <= ctrl[4] ? uart_tx : uart_rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
      rx_clk <= (rx_sample || rx_state == S_IDLE) ? '0 : rx_clk + CW'(1);
      // After a framing error the line is low, so no new falling edge appears until it has gone high again.
      case (rx_state)
        S_IDLE:   if (ctrl[1] && rx_s3 && !rx_s2) rx_state <= S_START;
        S_START:  if (rx_sample) begin
          rx_state <= rx_s2 ? S_IDLE : S_DATA; rx_bit <= '0;
        end
        S_DATA:   if (rx_sample) begin
          rx_sh <= {rx_s2, rx_sh[DATA_BITS-1:1]};
          if (rx_bit == LAST_BIT) rx_state <= ctrl[2] ? S_PARITY : S_STOP;
          else rx_bit <= rx_bit + 4'd1;
        end
        S_PARITY: if (rx_sample) rx_state <= S_STOP;
        S_STOP:   if (rx_sample) rx_state <= S_IDLE;
        default:  rx_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_uart_fifo.sv
// tb/tb_mmio_uart_fifo.sv - randomized self-checking bench for mmio_uart_fifo against a queue/waveform model
module tb_mmio_uart_fifo;
  localparam int CPB = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_rx = 1'b1;
  logic uart_tx, irq;
  int total = 0;
  int bad = 0;

  mmio_uart_fifo_if bus ();

  mmio_uart_fifo #(.CLK_FREQ(8), .BAUD_RATE(1), .DATA_BITS(8), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus), .uart_tx(uart_tx), .uart_rx(uart_rx), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk); bus.mem_we = 1'b1; bus.mem_addr = a; bus.mem_wdata = d;
    @(negedge clk); bus.mem_we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk); bus.mem_re = 1'b1; bus.mem_addr = a;
    @(negedge clk); bus.mem_re = 1'b0; d = bus.mem_rdata;
  endtask

  // Behavioural line receiver: finds a start bit on uart_tx and samples mid-bit.
  task automatic get_frame(input bit par_en, output logic [7:0] b, output logic p,
                           output logic stop, output bit ok);
    int t;
    ok = 0; b = '0; p = 1'b0; stop = 1'b0; t = 0;
    @(negedge clk);
    while (uart_tx !== 1'b0 && t < 600) begin @(negedge clk); t++; end
    if (t >= 600) return;
    repeat (3) @(negedge clk);
    if (uart_tx !== 1'b0) return;
    for (int i = 0; i < 8; i++) begin repeat (CPB) @(negedge clk); b[i] = uart_tx; end
    if (par_en) begin repeat (CPB) @(negedge clk); p = uart_tx; end
    repeat (CPB) @(negedge clk); stop = uart_tx; ok = 1;
  endtask

  task automatic send_rx(input logic [7:0] b, input bit has_par, input logic par, input logic stop);
    logic [10:0] bits;
    int n;
    n = has_par ? 11 : 10;
    bits = has_par ? {stop, par, b, 1'b0} : {1'b0, stop, b, 1'b0};
    for (int k = 0; k < n; k++) begin
      @(negedge clk); uart_rx = bits[k];
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk); uart_rx = 1'b1;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL reset_tx got %b want 1", uart_tx); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got %b want 0", irq); end
    total++; if (bus.mem_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got %h want 0", bus.mem_rdata); end
    rd(4'h4, d);
    total++; if (d !== 32'h00A) begin bad++; $display("FAIL reset_status got %h want 00a", d); end
    rd(4'h8, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_ctrl got %h want 0", d); end
  endtask

  task automatic test_regs;
    logic [31:0] d;
    wr(4'h8, 32'h0000_0040);
    repeat (3) @(negedge clk);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL tx_irq got %b want 1", irq); end
    wr(4'h8, 32'h0000_0020);
    repeat (3) @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rx_irq_empty got %b want 0", irq); end
    wr(4'hC, 32'hFFFF_FFFF);
    rd(4'hC, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL unmapped_read got %h want 0", d); end
    rd(4'h8, d);
    total++; if (d !== 32'h20) begin bad++; $display("FAIL ctrl_readback got %h want 20", d); end
    wr(4'h8, 32'h0);
  endtask

  task automatic test_tx_wave;
    logic [7:0] b, seg, got;
    logic [9:0] frame;
    logic [31:0] d;
    logic p, s;
    bit ok;
    int t;
    b = 8'hA5;
    frame = {1'b1, b, 1'b0};
    wr(4'h8, 32'h1);
    wr(4'h0, {24'h0, b});
    t = 0;
    @(negedge clk);
    while (uart_tx !== 1'b0 && t < 100) begin @(negedge clk); t++; end
    total++; if (t >= 100) begin bad++; $display("FAIL tx_start_timeout got %0d cycles want <100", t); end
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < CPB; c++) begin
        seg[c] = uart_tx;
        @(negedge clk);
      end
      total++;
      if (seg !== {8{frame[k]}}) begin bad++; $display("FAIL tx_bit%0d got %b want %b", k, seg, {8{frame[k]}}); end
    end
    repeat (4) @(negedge clk);
    total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL tx_idle got %b want 1", uart_tx); end
    rd(4'h4, d);
    total++; if (d[4:0] !== 5'b01010) begin bad++; $display("FAIL tx_done_status got %b want 01010", d[4:0]); end
    b = 8'($urandom);
    wr(4'h0, {24'h0, b});
    get_frame(1'b0, got, p, s, ok);
    total++; if (!ok || got !== b || s !== 1'b1) begin bad++; $display("FAIL tx_rand got %h/%b want %h/1", got, s, b); end
  endtask

  task automatic test_parity;
    logic [7:0] b, got;
    logic [31:0] d;
    logic p, s;
    bit ok;
    wr(4'h8, 32'h0D);
    b = 8'($urandom);
    wr(4'h0, {24'h0, b});
    get_frame(1'b1, got, p, s, ok);
    total++; if (!ok || got !== b) begin bad++; $display("FAIL par_tx_data got %h want %h", got, b); end
    total++; if (p !== (^b ^ 1'b1)) begin bad++; $display("FAIL par_tx_odd got %b want %b", p, ^b ^ 1'b1); end
    wr(4'h8, 32'h06);
    b = 8'($urandom);
    send_rx(b, 1'b1, ~(^b), 1'b1);
    rd(4'h4, d);
    total++; if (d[7] !== 1'b1) begin bad++; $display("FAIL parity_err got %b want 1", d[7]); end
    rd(4'h0, d);
    total++; if (d !== {24'h0, b}) begin bad++; $display("FAIL parity_kept got %h want %h", d, b); end
    wr(4'h4, 32'h80);
    rd(4'h4, d);
    total++; if (d[7] !== 1'b0) begin bad++; $display("FAIL parity_w1c got %b want 0", d[7]); end
  endtask

  task automatic test_loopback;
    logic [7:0] q[$];
    logic [7:0] b;
    logic [31:0] d;
    for (int pass = 0; pass < 2; pass++) begin
      q = {};
      uart_rx = 1'b0;
      wr(4'h8, pass == 0 ? 32'h17 : 32'h1F);
      if (pass == 0) q = '{8'h3C, 8'h81, 8'h00};
      else for (int i = 0; i < DEPTH; i++) q.push_back(8'($urandom));
      foreach (q[i]) wr(4'h0, {24'h0, q[i]});
      repeat (q.size() * 11 * CPB + 40) @(negedge clk);
      rd(4'h4, d);
      total++; if (d[3] !== 1'b0 || d[7] !== 1'b0) begin bad++; $display("FAIL lb%0d_status got %h want rx_empty=0 parity_err=0", pass, d); end
      while (q.size() > 0) begin
        b = q.pop_front();
        rd(4'h0, d);
        total++; if (d !== {24'h0, b}) begin bad++; $display("FAIL lb%0d_data got %h want %h", pass, d, b); end
      end
    end
    wr(4'h8, 32'h0);
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_tx_drop;
    logic [7:0] q[$];
    logic [7:0] b, got;
    logic [31:0] d;
    logic p, s;
    bit ok, dropped;
    dropped = 0;
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      if (q.size() < DEPTH) q.push_back(b); else dropped = 1;
      wr(4'h0, {24'h0, b});
    end
    rd(4'h4, d);
    total++; if (d[0] !== (q.size() == DEPTH) || d[8] !== dropped) begin bad++; $display("FAIL drop_status got %h want tx_full=1 tx_drop=1", d); end
    wr(4'h8, 32'h1);
    while (q.size() > 0) begin
      b = q.pop_front();
      get_frame(1'b0, got, p, s, ok);
      total++; if (!ok || got !== b) begin bad++; $display("FAIL drop_frame got %h want %h", got, b); end
    end
    get_frame(1'b0, got, p, s, ok);
    total++; if (ok) begin bad++; $display("FAIL drop_extra got frame %h want none", got); end
    wr(4'h4, 32'h100);
    rd(4'h4, d);
    total++; if (d[8] !== 1'b0) begin bad++; $display("FAIL drop_w1c got %b want 0", d[8]); end
    wr(4'h8, 32'h0);
  endtask

  task automatic test_frame_err;
    logic [7:0] b;
    logic [31:0] d;
    wr(4'h8, 32'h82);
    send_rx(8'($urandom), 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    rd(4'h4, d);
    total++; if (d[6] !== 1'b1 || d[3] !== 1'b1) begin bad++; $display("FAIL ferr_status got %h want frame_err=1 rx_empty=1", d); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL ferr_irq got %b want 1", irq); end
    wr(4'h4, 32'h40);
    repeat (3) @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL ferr_irq_clear got %b want 0", irq); end
    b = 8'($urandom);
    send_rx(b, 1'b0, 1'b0, 1'b1);
    rd(4'h0, d);
    total++; if (d !== {24'h0, b}) begin bad++; $display("FAIL ferr_rearm got %h want %h", d, b); end
  endtask

  task automatic test_overrun;
    logic [7:0] q[$];
    logic [7:0] b;
    logic [31:0] d;
    wr(4'h8, 32'h02);
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom);
      if (q.size() < DEPTH) q.push_back(b);
      send_rx(b, 1'b0, 1'b0, 1'b1);
    end
    rd(4'h4, d);
    total++; if (d[5] !== 1'b1 || d[2] !== 1'b1) begin bad++; $display("FAIL ovr_status got %h want overrun=1 rx_full=1", d); end
    while (q.size() > 0) begin
      b = q.pop_front();
      rd(4'h0, d);
      total++; if (d !== {24'h0, b}) begin bad++; $display("FAIL ovr_data got %h want %h", d, b); end
    end
    rd(4'h0, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL ovr_empty_read got %h want 0", d); end
    wr(4'h4, 32'h20);
    rd(4'h4, d);
    total++; if (d[5] !== 1'b0 || d[3] !== 1'b1) begin bad++; $display("FAIL ovr_w1c got %h want overrun=0 rx_empty=1", d); end
  endtask

  task automatic test_mid_reset;
    logic [31:0] d;
    int t, lows;
    wr(4'h8, 32'h02);
    send_rx(8'($urandom), 1'b0, 1'b0, 1'b1);
    wr(4'h8, 32'h23);
    wr(4'h0, 32'h0);
    rd(4'h8, d);
    t = 0;
    while (uart_tx !== 1'b0 && t < 100) begin @(negedge clk); t++; end
    repeat (20) @(negedge clk);
    total++; if (uart_tx !== 1'b0 || irq !== 1'b1) begin bad++; $display("FAIL pre_reset got tx=%b irq=%b want 0/1", uart_tx, irq); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (uart_tx !== 1'b1 || irq !== 1'b0 || bus.mem_rdata !== 32'h0) begin
      bad++; $display("FAIL mid_reset got tx=%b irq=%b rdata=%h want 1/0/0", uart_tx, irq, bus.mem_rdata);
    end
    rst = 1'b0;
    rd(4'h4, d);
    total++; if (d !== 32'h00A) begin bad++; $display("FAIL mid_reset_status got %h want 00a", d); end
    rd(4'h8, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL mid_reset_ctrl got %h want 0", d); end
    lows = 0;
    repeat (100) begin @(negedge clk); if (uart_tx !== 1'b1) lows++; end
    total++; if (lows != 0) begin bad++; $display("FAIL mid_reset_quiet got %0d low cycles want 0", lows); end
  endtask

  initial begin
    bus.mem_we = 1'b0; bus.mem_re = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_regs();
    test_tx_wave();
    test_parity();
    test_loopback();
    test_tx_drop();
    test_frame_err();
    test_overrun();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mmio_uart_fifo.md
Name: mmio_uart_fifo

Overview:
Second-generation memory-mapped UART for the RISC-V core's MMIO space. It replaces the single-byte, start-strobed UART with CPU-visible registers, parametrised TX/RX FIFOs, an optional parity bit, an internal loopback mode and sticky error flags. It sits on the core's data-memory bus beside data RAM. Its serial pins go to the board UART.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz
BAUD_RATE, 200000, serial bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer, must be >= 4)
DATA_BITS, 8, payload bits per frame (5..8)
FIFO_DEPTH, 8, entries per FIFO (power of two, >= 2)

Ports:
clk  in  1  system clock; all logic is on the rising edge
rst  in  1  synchronous, active-high reset
mem_we  in  1  bus write strobe (one cycle)
mem_re  in  1  bus read strobe (one cycle)
mem_addr  in  4  byte offset: 0x0 DATA, 0x4 STATUS, 0x8 CTRL
mem_wdata  in  32  write data
mem_rdata  out  32  registered read data
uart_tx  out  1  serial out, idle high
uart_rx  in  1  serial in, asynchronous
irq  out  1  level interrupt

Behaviour:
- Reset values: uart_tx=1, mem_rdata=0, irq=0, both FIFOs empty, CTRL=0, sticky flags 0, both FSMs in IDLE.
- A reset asserted mid-frame aborts the frame. uart_tx returns to 1 on the next cycle.
- Read latency: mem_rdata is valid the cycle after mem_re. mem_rdata holds its value when mem_re is low.
- Unmapped offsets read 0 and ignore writes.
- DATA write: pushes wdata[DATA_BITS-1:0] into the TX FIFO. If the TX FIFO is full, the push is dropped and tx_drop is set.
- DATA read: returns the RX FIFO head zero-extended, and pops it. An empty RX FIFO returns 0 with no pop.
- STATUS bits (read-only except the sticky flags):
  - [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] tx_busy
  - [5] overrun, [6] frame_err, [7] parity_err, [8] tx_drop
  - [5:8] are sticky; writing 1 to a bit clears it.
- CTRL bits (read/write):
  - [0] tx_en, [1] rx_en, [2] parity_en, [3] parity_odd, [4] loopback
  - [5] rx_irq_en: irq when RX FIFO not empty
  - [6] tx_irq_en: irq when TX FIFO empty and TX idle
  - [7] err_irq_en: irq when any sticky flag is set
- irq: OR of the enabled causes, registered (1-cycle delay).
- FIFOs: circular, log2(FIFO_DEPTH)-bit pointers plus count. A simultaneous push and pop on a full or empty FIFO is legal; count is unchanged and the data order is preserved.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START when tx_en=1 and the TX FIFO is non-empty; the head pops on that transition.
  - Each state lasts CLKS_PER_BIT cycles.
  - Data is sent LSB first, bit index 0..DATA_BITS-1.
  - PARITY is skipped when parity_en=0. Parity value = XOR of the data bits, XOR parity_odd.
  - STOP is one bit, then IDLE. Back-to-back frames have no idle gap.
  - tx_busy = state != IDLE.
  - Clearing tx_en mid-frame completes the current frame.
- RX path: uart_rx passes through a 2-flop synchroniser. When loopback=1, the synchroniser input is uart_tx and the uart_rx pin is ignored.
- RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on a synchronised 1->0 edge when rx_en=1.
  - START samples at CLKS_PER_BIT/2. If the line is high (a glitch), return to IDLE with no flag.
  - Each later bit is sampled CLKS_PER_BIT after the previous sample.
  - parity_err is set on a mismatch, but the byte is still stored.
  - STOP sampled 0: set frame_err, discard the byte, and wait for the line to go high before re-arming.
  - STOP sampled 1: push the byte. If the RX FIFO is full, drop the new byte and set overrun; the older data is kept.
- Simultaneous events on the same cycle:
  - A CPU pop and an RX push both apply.
  - A hardware set and a W1C clear of the same flag: the set wins.
  - A DATA write while TX pops: both apply.

Test Plan:
- CLK_FREQ=8, BAUD_RATE=1 (8 clk/bit), write CTRL=0x01, write DATA=0xA5 -> uart_tx low for 8 cycles, then 1,0,1,0,0,1,0,1 (8 cycles each), then high; tx_empty=1 and tx_busy=0 afterwards.
- CTRL=0x17 (loopback, parity even, tx/rx enabled), write 0x3C, 0x81, 0x00 -> after ~3×11×8 cycles, STATUS rx_empty=0; three DATA reads return 0x3C, 0x81, 0x00; parity_err=0.
- FIFO_DEPTH=4, tx_en=0, write 6 bytes -> tx_full=1, tx_drop=1; then tx_en=1 -> exactly the first 4 bytes are transmitted; write STATUS bit 8 -> tx_drop reads 0.
- Drive uart_rx externally with a frame whose stop bit is 0 -> frame_err=1 and rx_empty=1; with err_irq_en=1, irq rises.
- Send 5 frames into an RX FIFO of depth 4 without reading -> overrun=1; reads return the first 4 bytes in order.
- Assert rst during the DATA phase of TX -> the next cycle uart_tx=1, all registers are at their reset values, and STATUS reads 0x00A (tx_empty and rx_empty).
